// File: rtl/control_recibir_param_pkg.sv
// rtl/control_recibir_param_pkg.sv - shared state encodings and width helper for the capture sequencer
package control_recibir_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_ACTIVE  = 2'b10
    } state_e;

    // Counter/index width that never collapses to zero bits for tiny ranges
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/control_recibir_param_contador_timeout.sv
// rtl/control_recibir_param_contador_timeout.sv - saturating idle counter with terminal-count pulse
module contador_timeout
    import control_recibir_param_pkg::*;
#(
    parameter int unsigned N = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W    = clog2_min1(N + 1);
    localparam int unsigned LAST = (N == 0) ? 0 : N - 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority; count up while enabled and hold at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr || (N == 0)) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST[W-1:0])) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose edge would complete N idle cycles; N=0 never fires
    assign tc = (N != 0) && en && !clr && (cnt_q == LAST[W-1:0]);

endmodule

// File: rtl/control_recibir_param.sv
// rtl/control_recibir_param.sv - PS/2 digit capture sequencer with backspace, cancel and timeout
module control_recibir_param
    import control_recibir_param_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS     = 4,
    parameter  int unsigned ACTIVE_CYCLES  = 2,
    parameter  int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned IDX_W          = clog2_min1(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio_datos,
    input  logic                  cod_verificado,
    input  logic                  cod_borrar,
    input  logic                  cod_cancelar,
    output logic [NUM_DIGITS-1:0] registros,
    output logic [IDX_W-1:0]      indice,
    output logic                  active,
    output logic                  ocupado,
    output logic                  error_timeout
);

    localparam int unsigned ACT_W = clog2_min1(ACTIVE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(ACTIVE_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] indice_q;
    logic [IDX_W-1:0] indice_d;
    logic [ACT_W-1:0] act_cnt_q;
    logic [ACT_W-1:0] act_cnt_d;
    logic             err_q;
    logic             err_d;

    logic in_capture;
    logic evento;
    logic tmr_tc;

    // A digit or backspace key restarts the idle window; outside CAPTURE the timer is held at 0
    assign in_capture = (state_q == ST_CAPTURE);
    assign evento     = cod_verificado || cod_borrar;

    contador_timeout #(
        .N (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (!in_capture || evento),
        .en  (in_capture),
        .tc  (tmr_tc)
    );

    // Next state: cancel beats digit beats backspace beats timeout
    always_comb begin
        state_d   = state_q;
        indice_d  = indice_q;
        act_cnt_d = act_cnt_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inicio_datos) begin
                    state_d  = ST_CAPTURE;
                    indice_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (cod_cancelar) begin
                    state_d  = ST_IDLE;
                    indice_d = '0;
                end else if (cod_verificado) begin
                    if (indice_q == LAST_IDX) begin
                        state_d   = ST_ACTIVE;
                        indice_d  = '0;
                        act_cnt_d = '0;
                    end else begin
                        indice_d = indice_q + IDX_W'(1);
                    end
                end else if (cod_borrar) begin
                    if (indice_q != '0) begin
                        indice_d = indice_q - IDX_W'(1);
                    end
                end else if (tmr_tc) begin
                    state_d  = ST_IDLE;
                    indice_d = '0;
                    err_d    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (act_cnt_q == ACT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    act_cnt_d = act_cnt_q + ACT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                indice_d  = '0;
                act_cnt_d = '0;
            end
        endcase
    end

    // State, index, active counter and error pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            indice_q  <= '0;
            act_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            indice_q  <= indice_d;
            act_cnt_q <= act_cnt_d;
            err_q     <= err_d;
        end
    end

    // Moore outputs decoded from registered state
    assign registros     = in_capture ? (NUM_DIGITS'(1) << indice_q) : '0;
    assign indice        = indice_q;
    assign active        = (state_q == ST_ACTIVE);
    assign ocupado       = in_capture;
    assign error_timeout = err_q;

endmodule
